// File: rtl/fifo_framer_rd.sv
// fifo_framer_rd: pops a show-ahead FIFO of {eof,byte} words and frames bytes
// onto a ready/valid stream. Define FRAMER_CSUM_EN to append an XOR checksum.
//
// Ports:
//   clk, rstn        clock, asynchronous active-low reset
//   fifo_data        FIFO head word (bit 8 = end of frame, 7:0 = payload)
//   fifo_emptyp      FIFO empty flag
//   fifo_readp       FIFO pop strobe (combinational)
//   out_data/valid   registered output byte and its valid flag
//   out_ready        downstream accept
//   out_last         final byte of the frame
//   frame_len        byte count of the last completed frame
//   frame_done       pulse after the last byte is accepted
//   err_overlen      pulse when a frame is cut at MAXLEN
module fifo_framer_rd #(
  parameter int BITSIZE = 9,
  parameter int MAXLEN  = 64
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [BITSIZE-1:0] fifo_data,
  input  logic               fifo_emptyp,
  output logic               fifo_readp,
  output logic [7:0]         out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic [6:0]         frame_len,
  output logic               frame_done,
  output logic               err_overlen
);

  localparam logic [6:0] MAX7 = 7'(MAXLEN);

`ifdef FRAMER_CSUM_EN
  typedef enum logic [1:0] {
    IDLE,
    XFER,
    CSUM
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE,
    XFER
  } state_t;
`endif

  state_t     state;
  logic [6:0] cnt;
  logic [6:0] cnt_inc;
  logic       out_free;
  logic       in_run;
  logic       eof;

`ifdef FRAMER_CSUM_EN
  logic [7:0] csum;
`endif

  assign out_free = ~out_valid | out_ready;
  assign in_run   = (state == IDLE) || (state == XFER);
  assign cnt_inc  = cnt + 7'd1;
  // A frame ends on the flag or when the count reaches MAXLEN.
  assign eof      = fifo_data[8] | (cnt_inc == MAX7);

  assign fifo_readp = rstn & ~fifo_emptyp
                    & out_free & in_run;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      cnt         <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      frame_len   <= '0;
      frame_done  <= 1'b0;
      err_overlen <= 1'b0;
`ifdef FRAMER_CSUM_EN
      csum        <= '0;
`endif
    end else begin
      frame_done  <= out_valid & out_ready & out_last;
      err_overlen <= 1'b0;
      if (fifo_readp) begin
        out_data  <= fifo_data[7:0];
        out_valid <= 1'b1;
        if (eof) begin
          frame_len   <= cnt_inc;
          cnt         <= '0;
          // eof without the flag can only be the length cut
          err_overlen <= ~fifo_data[8];
`ifdef FRAMER_CSUM_EN
          out_last    <= 1'b0;
          csum        <= csum ^ fifo_data[7:0];
          state       <= CSUM;
`else
          out_last    <= 1'b1;
          state       <= IDLE;
`endif
        end else begin
          out_last <= 1'b0;
          cnt      <= cnt_inc;
          state    <= XFER;
`ifdef FRAMER_CSUM_EN
          csum     <= csum ^ fifo_data[7:0];
`endif
        end
`ifdef FRAMER_CSUM_EN
      end else if (state == CSUM && out_free) begin
        out_data  <= csum;
        out_valid <= 1'b1;
        out_last  <= 1'b1;
        csum      <= '0;
        state     <= IDLE;
`endif
      end else if (out_free) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: doc/fifo_framer_rd.md
FIFO_FRAMER_RD -- requirements
Module: fifo_framer_rd

Interface
REQ-001: Parameter BITSIZE, default 9, FIFO word width: bit 8 = end-of-frame flag, bits 7:0 = payload byte.
REQ-002: Parameter MAXLEN, default 64, maximum payload bytes per frame before forced termination.
REQ-003: clk  input  1  sole clock, all state on rising edge.
REQ-004: rstn  input  1  reset, asynchronous, active-low.
REQ-005: fifo_data  input  BITSIZE  upstream FIFO head word, show-ahead (valid whenever fifo_emptyp=0).
REQ-006: fifo_emptyp  input  1  upstream FIFO empty flag.
REQ-007: fifo_readp  output  1  pop strobe to upstream FIFO, combinational.
REQ-008: out_data  output  8  registered output byte.
REQ-009: out_valid  output  1  out_data holds a byte.
REQ-010: out_ready  input  1  downstream accepts byte when out_valid=1 and out_ready=1.
REQ-011: out_last  output  1  current out_data is the final byte of the frame.
REQ-012: frame_len  output  7  payload byte count of the most recently completed frame.
REQ-013: frame_done  output  1  one-cycle pulse when the final byte of a frame is accepted.
REQ-014: err_overlen  output  1  one-cycle pulse when a frame is force-terminated at MAXLEN.

Function
REQ-015: Output register is "free" when out_valid=0 or (out_valid=1 and out_ready=1).
REQ-016: fifo_readp = 1 iff fifo_emptyp=0, output register free, and state is IDLE or XFER; never asserted while fifo_emptyp=1.
REQ-017: On a pop, out_data <= fifo_data[7:0], out_valid <= 1 on the same edge; latency FIFO head to out_valid is one cycle.
REQ-018: Output register free with no pop and no checksum load -> out_valid <= 0; not free -> out_data/out_valid/out_last held stable.
REQ-019: FSM states IDLE, XFER, CSUM; IDLE -> XFER on first pop of a frame; XFER -> IDLE (or CSUM, per REQ-029) on the pop that ends the frame.
REQ-020: A frame ends on a pop with fifo_data[8]=1, or on the pop making the running count equal MAXLEN.
REQ-021: Running byte count: 7 bits, cleared at frame start, +1 per pop, no wrap within MAXLEN<=127.
REQ-022: Forced end at MAXLEN with fifo_data[8]=0 -> err_overlen pulses on that pop edge; next word starts a new frame.
REQ-023: frame_len is updated with the running count when the frame ends and held until the next frame ends.
REQ-024: frame_done pulses on the cycle after the out_last byte is accepted (out_valid=1, out_ready=1, out_last=1).
REQ-025: A one-byte frame (flag set on first word) passes IDLE -> IDLE (no CSUM_EN) with frame_len=1.
REQ-026: Back-to-back frames sustain one byte per cycle when out_ready=1 and the FIFO is non-empty, CSUM state excepted.

Reset
REQ-027: rstn=0 asynchronously forces state IDLE, out_valid=0, out_data=0, out_last=0, frame_len=0, frame_done=0, err_overlen=0, running count and checksum 0; fifo_readp=0 while rstn=0.
REQ-028: Reset mid-frame discards the partial frame; no frame_done is generated for it.

Configuration
REQ-029: Macro FRAMER_CSUM_EN defined: running XOR of payload bytes kept; the frame-ending pop loads its byte with out_last=0 and enters CSUM; in CSUM with output register free, out_data <= XOR, out_last <= 1, no pop, -> IDLE.
REQ-030: FRAMER_CSUM_EN undefined: no checksum logic, no CSUM state; the frame-ending byte carries out_last=1.

Verification
REQ-031: FIFO words 0x011,0x022,0x133, out_ready=1, no CSUM_EN -> out 11,22,33 on consecutive cycles, out_last only on 33, frame_len=3, one frame_done.
REQ-032: Same stimulus with FRAMER_CSUM_EN -> out 11,22,33,00 (XOR), out_last only on 00, frame_len=3.
REQ-033: 70 words all bit8=0, MAXLEN=64 -> err_overlen pulse on pop 64, frame_len=64, remaining 6 bytes start a new frame.
REQ-034: out_ready held 0 for 5 cycles mid-frame -> out_data stable, fifo_readp=0, no byte lost or duplicated after release.
REQ-035: fifo_emptyp=1 with out_ready=1 -> fifo_readp=0, out_valid drops to 0 after the pending byte is accepted.
REQ-036: rstn pulsed low after 2 of 4 bytes -> all outputs at reset values immediately, no frame_done, next frame frame_len counts from 1.
